// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache and D-cache.
// Serves one transaction at a time and keeps saturating per-requester grant counters.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  arb_busy,
  output logic [CNT_WIDTH-1:0]  icache_grants,
  output logic [CNT_WIDTH-1:0]  dcache_grants
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  dwr_q, dwr_d;
  logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
  logic [LINE_WIDTH-1:0] drdata_q, drdata_d;
  logic [CNT_WIDTH-1:0]  icnt_q, icnt_d;
  logic [CNT_WIDTH-1:0]  dcnt_q, dcnt_d;
  logic                  i_req, d_req, grant_d, grant_i;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  // On a tie the requester that did not win last time gets the port.
  assign grant_d = d_req && (!i_req || !last_d_q);
  assign grant_i = i_req && !grant_d;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    dwr_d    = dwr_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    icnt_d   = icnt_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          dwr_d   = dcache_write;
        end else if (grant_i) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          irdata_d = pmem_rdata;
          last_d_d = 1'b0;
          state_d  = RESP_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          drdata_d = pmem_rdata;
          last_d_d = 1'b1;
          state_d  = RESP_D;
        end
      end
      RESP_I: begin
        icnt_d  = sat_inc(icnt_q);
        state_d = IDLE;
      end
      RESP_D: begin
        dcnt_d  = sat_inc(dcnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      dwr_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      dwr_q    <= dwr_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Read/write choice is latched at grant so the strobes depend only on registered state.
  assign pmem_read     = (state_q == SERVE_I) || ((state_q == SERVE_D) && !dwr_q);
  assign pmem_write    = (state_q == SERVE_D) && dwr_q;
  assign pmem_address  = (state_q == SERVE_I) ? icache_address :
                         (state_q == SERVE_D) ? dcache_address : '0;
  assign pmem_wdata    = pmem_write ? dcache_wdata : '0;
  assign icache_resp   = (state_q == RESP_I);
  assign dcache_resp   = (state_q == RESP_D);
  assign arb_busy      = (state_q != IDLE);
  assign icache_rdata  = irdata_q;
  assign dcache_rdata  = drdata_q;
  assign icache_grants = icnt_q;
  assign dcache_grants = dcnt_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed table, hand sequences, and randomized traffic
// checked against a transaction-level model; a 2-bit-counter instance exercises saturation.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic          dcache_read = 1'b0, dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  logic [LW-1:0] icache_rdata, dcache_rdata, pmem_wdata;
  logic          icache_resp, dcache_resp, pmem_read, pmem_write, arb_busy;
  logic [AW-1:0] pmem_address;
  logic [15:0]   icache_grants, dcache_grants;

  logic [LW-1:0] icache_rdata2, dcache_rdata2, pmem_wdata2;
  logic          icache_resp2, dcache_resp2, pmem_read2, pmem_write2, arb_busy2;
  logic [AW-1:0] pmem_address2;
  logic [1:0]    icache_grants2, dcache_grants2;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy), .icache_grants(icache_grants), .dcache_grants(dcache_grants)
  );

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata2), .icache_resp(icache_resp2),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata2), .dcache_resp(dcache_resp2),
    .pmem_read(pmem_read2), .pmem_write(pmem_write2), .pmem_address(pmem_address2),
    .pmem_wdata(pmem_wdata2), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy2), .icache_grants(icache_grants2), .dcache_grants(dcache_grants2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Transaction-level reference: owner 0=none 1=I 2=D; resp_now marks the completion cycle.
  bit            model_on = 1'b0, auto_stim = 1'b0, rst_en = 1'b0;
  int            req_pct = 30;
  int            m_owner = 0, m_resp = 0, m_icnt = 0, m_dcnt = 0;
  bit            m_last_d = 1'b0, m_dwr = 1'b0;
  logic [LW-1:0] m_idata = '0, m_ddata = '0;
  int            lat = 2, lat_cnt = 0;
  bit            i_drop = 1'b0, d_drop = 1'b0;
  int            order[$];

  task automatic tick();
    logic p_i, p_d, p_dw, p_resp, p_rst;
    logic [LW-1:0] p_rdata;
    p_i = icache_read; p_d = dcache_read | dcache_write; p_dw = dcache_write;
    p_resp = pmem_resp; p_rst = rst; p_rdata = pmem_rdata;
    @(posedge clk); #1;
    if (icache_resp) order.push_back(1);
    if (dcache_resp) order.push_back(2);
    if (!model_on) return;
    if (p_rst) begin
      m_owner = 0; m_resp = 0; m_last_d = 1'b0; m_dwr = 1'b0;
      m_icnt = 0; m_dcnt = 0; m_idata = '0; m_ddata = '0;
    end else if (m_resp != 0) begin
      if (m_resp == 1 && m_icnt < 65535) m_icnt++;
      if (m_resp == 2 && m_dcnt < 65535) m_dcnt++;
      m_resp = 0;
    end else if (m_owner != 0) begin
      if (p_resp) begin
        m_resp = m_owner;
        if (m_owner == 1) begin m_idata = p_rdata; m_last_d = 1'b0; end
        else begin m_ddata = p_rdata; m_last_d = 1'b1; end
        m_owner = 0;
      end
    end else begin
      if (p_i && p_d) m_owner = m_last_d ? 1 : 2;
      else if (p_i) m_owner = 1;
      else if (p_d) m_owner = 2;
      if (m_owner == 2) m_dwr = p_dw;
    end
    check("pmem_read", pmem_read, m_owner == 1 || (m_owner == 2 && !m_dwr));
    check("pmem_write", pmem_write, m_owner == 2 && m_dwr);
    if (m_owner == 1) check("pmem_address_i", pmem_address, icache_address);
    if (m_owner == 2) check("pmem_address_d", pmem_address, dcache_address);
    if (m_owner == 2 && m_dwr) check("pmem_wdata", pmem_wdata, dcache_wdata);
    check("icache_resp", icache_resp, m_resp == 1);
    check("dcache_resp", dcache_resp, m_resp == 2);
    check("arb_busy", arb_busy, m_owner != 0 || m_resp != 0);
    check("icache_rdata", icache_rdata, m_idata);
    check("dcache_rdata", dcache_rdata, m_ddata);
    check("icache_grants", icache_grants, m_icnt);
    check("dcache_grants", dcache_grants, m_dcnt);
    check("icache_grants_sat", icache_grants2, (m_icnt > 3) ? 3 : m_icnt);
    check("dcache_grants_sat", dcache_grants2, (m_dcnt > 3) ? 3 : m_dcnt);
    if (!auto_stim) return;
    if (m_owner != 0) begin
      lat_cnt++;
      pmem_rdata = rand_line();
      pmem_resp = (lat_cnt >= lat);
      if (pmem_resp) begin lat_cnt = 0; lat = $urandom_range(4, 1); end
    end else begin
      lat_cnt = 0;
      pmem_rdata = rand_line();
      pmem_resp = ($urandom_range(4) == 0);
    end
    if (rst) begin
      rst = 1'b0; icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
      i_drop = 1'b0; d_drop = 1'b0;
    end else if (rst_en && $urandom_range(399) == 0) begin
      rst = 1'b1;
    end else begin
      if (m_resp == 1) i_drop = 1'b1;
      else if (i_drop) begin icache_read = 1'b0; i_drop = 1'b0; end
      else if (!icache_read && $urandom_range(99) < req_pct) begin
        icache_read = 1'b1; icache_address = $urandom & 32'hFFFF_FFE0;
      end
      if (m_resp == 2) d_drop = 1'b1;
      else if (d_drop) begin dcache_read = 1'b0; dcache_write = 1'b0; d_drop = 1'b0; end
      else if (!(dcache_read || dcache_write) && $urandom_range(99) < req_pct) begin
        case ($urandom_range(2))
          0: begin dcache_read = 1'b1; dcache_write = 1'b0; end
          1: begin dcache_read = 1'b0; dcache_write = 1'b1; end
          default: begin dcache_read = 1'b1; dcache_write = 1'b1; end
        endcase
        dcache_address = $urandom & 32'hFFFF_FFE0;
        dcache_wdata = rand_line();
      end
    end
  endtask

  typedef struct {
    logic ir, dr, dw, pr;
    logic [7:0] rd;
    logic epr, epw, eir, edr, eb;
    int own;
    logic [7:0] eid, edd;
    int eic, edc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int nrd, nwr, nir, ndr, bad_addr, bad_wd;
    bit drop;
    logic [LW-1:0] got;

    // Simultaneous reads out of reset, then a stray memory response and a read+write request.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h00, 8'h00, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h00, 8'h00, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h00, 8'h3C, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h3C, 0, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h00, 8'h3C, 0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h5A, 8'h3C, 0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h5A, 8'h3C, 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h5A, 8'h3C, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8'h5A, 8'h3C, 1, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h5A, 8'h77, 1, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h5A, 8'h77, 1, 2};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_resp", {icache_resp, dcache_resp}, 2'b00);
    check("rst_counters", {icache_grants, dcache_grants}, 32'h0);
    check("rst_rdata", icache_rdata | dcache_rdata, '0);
    check("rst_address", pmem_address, '0);

    // Single I read, memory answers on the 4th strobe cycle.
    icache_read = 1'b1; icache_address = 32'h0000_0060;
    nrd = 0; nir = 0; ndr = 0; bad_addr = 0; drop = 1'b0; got = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (drop) icache_read = 1'b0;
      drop = icache_resp;
      if (pmem_read) begin nrd++; if (pmem_address != 32'h60) bad_addr++; end
      if (icache_resp) begin nir++; got = icache_rdata; end
      if (dcache_resp) ndr++;
      pmem_resp = pmem_read && nrd == 4;
      pmem_rdata = pmem_resp ? {32{8'hA5}} : '0;
    end
    check("iread_strobe_cycles", nrd, 4);
    check("iread_address", bad_addr, 0);
    check("iread_resp_pulses", nir, 1);
    check("iread_no_dresp", ndr, 0);
    check("iread_rdata", got, {32{8'hA5}});
    check("iread_grants", icache_grants, 1);

    // D write-back, memory answers in the first strobe cycle.
    dcache_write = 1'b1; dcache_address = 32'h0000_1000; dcache_wdata = {8{32'h1234_5678}};
    nrd = 0; nwr = 0; ndr = 0; bad_wd = 0; drop = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (drop) dcache_write = 1'b0;
      drop = dcache_resp;
      if (pmem_read) nrd++;
      if (pmem_write) begin
        nwr++;
        if (pmem_wdata != {8{32'h1234_5678}} || pmem_address != 32'h1000) bad_wd++;
      end
      if (dcache_resp) ndr++;
      pmem_resp = pmem_write;
    end
    check("dwr_strobe_cycles", nwr, 1);
    check("dwr_no_read", nrd, 0);
    check("dwr_wdata_addr", bad_wd, 0);
    check("dwr_resp_pulses", ndr, 1);
    check("dwr_grants", dcache_grants, 1);

    rst = 1'b1; tick(); rst = 1'b0;
    icache_address = 32'h0000_0060; dcache_address = 32'h0000_1000;
    dcache_wdata = {8{32'h1234_5678}};
    foreach (tbl[r]) begin
      icache_read = tbl[r].ir; dcache_read = tbl[r].dr; dcache_write = tbl[r].dw;
      pmem_resp = tbl[r].pr; pmem_rdata = {32{tbl[r].rd}};
      tick();
      check($sformatf("tbl%0d_pmem_read", r), pmem_read, tbl[r].epr);
      check($sformatf("tbl%0d_pmem_write", r), pmem_write, tbl[r].epw);
      check($sformatf("tbl%0d_icache_resp", r), icache_resp, tbl[r].eir);
      check($sformatf("tbl%0d_dcache_resp", r), dcache_resp, tbl[r].edr);
      check($sformatf("tbl%0d_busy", r), arb_busy, tbl[r].eb);
      check($sformatf("tbl%0d_icache_rdata", r), icache_rdata, {32{tbl[r].eid}});
      check($sformatf("tbl%0d_dcache_rdata", r), dcache_rdata, {32{tbl[r].edd}});
      check($sformatf("tbl%0d_icache_grants", r), icache_grants, tbl[r].eic);
      check($sformatf("tbl%0d_dcache_grants", r), dcache_grants, tbl[r].edc);
      if (tbl[r].own == 1) check($sformatf("tbl%0d_addr", r), pmem_address, 32'h60);
      if (tbl[r].own == 2) check($sformatf("tbl%0d_addr", r), pmem_address, 32'h1000);
      if (tbl[r].epw) check($sformatf("tbl%0d_wdata", r), pmem_wdata, {8{32'h1234_5678}});
    end

    // Reset while a D read is in flight; a late memory response must be dropped.
    icache_read = 1'b0; dcache_read = 1'b1; dcache_write = 1'b0; pmem_resp = 1'b0;
    dcache_address = 32'h0000_2000;
    tick(); tick();
    check("midrst_pre_read", pmem_read, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0; dcache_read = 1'b0;
    check("midrst_pmem_read", pmem_read, 1'b0);
    check("midrst_busy", arb_busy, 1'b0);
    check("midrst_counters", {icache_grants, dcache_grants}, 32'h0);
    check("midrst_dresp", dcache_resp, 1'b0);
    pmem_resp = 1'b1; pmem_rdata = {32{8'hC3}};
    ndr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      pmem_resp = 1'b0;
      if (dcache_resp || arb_busy) ndr++;
    end
    check("midrst_late_resp_ignored", ndr, 0);
    check("midrst_rdata_kept", dcache_rdata, '0);

    // Both requesters continuously active: grants alternate starting with D.
    model_on = 1'b1; auto_stim = 1'b1; rst_en = 1'b0; req_pct = 100;
    icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    rst = 1'b1;
    tick();
    order.delete();
    for (int c = 0; c < 400 && order.size() < 6; c++) tick();
    tick();
    check("alt_count", order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++)
      check($sformatf("alt_order%0d", k), order[k], (k % 2 == 0) ? 2 : 1);
    check("alt_icache_grants", icache_grants, 3);
    check("alt_dcache_grants", dcache_grants, 3);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    req_pct = 30; rst_en = 1'b1; rst = 1'b1;
    for (int c = 0; c < 4000; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
